riscv_id: RTL and testbench
===========================

Name: riscv_id

Overview:
RV32I decode stage, directly upstream of riscv_ex. It accepts one instruction per transfer from fetch over an if_id rdy/ack handshake. It holds the 32x32 integer register file, which is written by the WB stage's wb_rf_* port. A per-register scoreboard resolves RAW and WAW hazards by stalling. A registered output slot drives the id_ex_* bundle consumed by riscv_ex.

Parameters:
EX_FUNCT_W, 4, width of id_ex_funct
MEM_FUNCT_W, 4, width of id_ex_mem_funct

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
if_id_rdy  in  1  fetch has a valid instruction
if_id_ack  out  1  decode accepts instruction this cycle
if_id_instr  in  32  instruction word
if_id_pc  in  32  instruction address
id_ex_rdy  out  1  output slot valid
id_ex_ack  in  1  EX consumes output slot
id_ex_funct  out  EX_FUNCT_W  ALU op
id_ex_op1  out  32  ALU operand 1
id_ex_op2  out  32  ALU operand 2
id_ex_mem_funct  out  MEM_FUNCT_W  memory op
id_ex_mem_data  out  32  store data
id_ex_wb_rsd  out  5  destination register, 0 = none
wb_rf_data  in  32  writeback data
wb_rf_rsd  in  5  writeback register
wb_rf_write  in  1  writeback strobe
id_illegal  out  1  one-cycle pulse: an unsupported instruction was consumed

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous, active-low.
- Reset values:
  - Register file x1..x31 = 0 and scoreboard busy[31:1] = 0.
  - id_ex_rdy = 0, id_illegal = 0.
  - id_ex_funct, id_ex_op1, id_ex_op2, id_ex_mem_funct, id_ex_mem_data and id_ex_wb_rsd are all 0.
- Handshake: a transfer happens on a cycle where rdy & ack are both high. The producer holds rdy and payload stable until the transfer.
- if_id_ack is combinational and is high when all of the following hold:
  - slot free: id_ex_rdy==0 or id_ex_ack==1;
  - no hazard.
- Hazard condition: any of these is busy and not being cleared by wb this cycle:
  - rs1, if the instruction uses it;
  - rs2, if the instruction uses it;
  - rd, if rd != 0.
- Illegal instructions consume regardless of hazard; they still require a free slot.
- Latency: an instruction accepted in cycle N has its payload valid with id_ex_rdy=1 in cycle N+1.
- Slot update: if an instruction is accepted, load the slot and set id_ex_rdy. Otherwise, if id_ex_ack is high, clear id_ex_rdy. Otherwise hold.
- Register read: x0 reads 0.
  - If wb_rf_write is high and wb_rf_rsd equals the source register (nonzero), the operand is wb_rf_data (write-through bypass).
- Register write: on wb_rf_write with wb_rf_rsd != 0, write the register and clear its busy bit. Writes to x0 are ignored.
- Scoreboard set: on acceptance of a legal instruction with rd != 0, set busy[rd]. If a set and a wb clear hit the same register in one cycle, set wins.
- Decode, with imm sign-extended:
  - OP: op1=rs1, op2=rs2; funct from funct3/funct7.
  - OP-IMM: op1=rs1, op2=imm_I. SRAI is funct7[5]; shift amount is imm[4:0].
  - LUI: op1=0, op2=imm_U, funct ADD.
  - AUIPC: op1=if_id_pc, op2=imm_U, funct ADD.
  - LOAD: op1=rs1, op2=imm_I, funct ADD, wb_rsd=rd.
  - STORE: op1=rs1, op2=imm_S, funct ADD, mem_data=rs2, wb_rsd=0.
  - Non-memory ops: mem_funct NONE, mem_data 0.
- EX funct encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- MEM funct encoding: NONE 0, LB 1, LH 2, LW 3, LBU 4, LHU 5, SB 6, SH 7, SW 8.
- Illegal/unsupported instructions: JAL, JALR, BRANCH, FENCE, SYSTEM, undefined opcodes or funct fields, and any instr[1:0] != 2'b11.
  - The instruction is consumed with no slot load and no scoreboard change.
  - id_illegal pulses in the next cycle.
- Reset mid-operation: all state returns to reset values immediately. A pending slot is dropped.

Test Plan:
- Back-to-back independent: ADDI x1,x0,5 then ADDI x2,x0,7 with id_ex_ack=1 -> consecutive cycles show funct 0, op1=0, op2=5, wb_rsd=1 and then op2=7, wb_rsd=2; if_id_ack stays high.
- RAW stall: ADDI x1,x0,5 followed by ADD x3,x1,x1 -> if_id_ack=0 until wb_rf_write with rsd=1, data=5. In that same cycle ADD is accepted; the next cycle shows op1=op2=5, wb_rsd=3.
- Store/load decode:
  - SW x2,-4(x1) with x1=0x100, x2=0xDEADBEEF -> op1=0x100, op2=0xFFFFFFFC, mem_funct 8, mem_data=0xDEADBEEF, wb_rsd=0.
  - LBU x4,3(x1) -> mem_funct 4, wb_rsd=4.
- Backpressure: hold id_ex_ack=0 for 3 cycles with if_id_rdy=1 -> payload stable, if_id_ack=0. Releasing ack transfers the slot and accepts the next instruction in the same cycle.
- Illegal and x0: JAL -> id_illegal pulses one cycle and id_ex_rdy stays 0. ADDI x0,x0,9 -> wb_rsd=0, no stall on a following read of x0, which reads 0.
- Async reset asserted while id_ex_rdy=1 and busy[5]=1 -> id_ex_rdy=0 immediately. After release, ADD x6,x5,x5 is accepted without stall and gives op1=0.

Source files
------------

// File: rtl/riscv_id.sv
// riscv_id -- RV32I decode stage feeding riscv_ex.
//
// Accepts one instruction per if_id transfer, reads operands from the
// 32x32 integer register file (with write-through bypass from WB), stalls
// on RAW/WAW hazards using a per-register busy scoreboard, and presents the
// decoded operation in a registered id_ex output slot.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   if_id_*           fetch -> decode handshake (rdy/ack) with instr and pc
//   id_ex_*           decode -> execute slot (rdy/ack) with ALU/mem payload
//   wb_rf_*           writeback port into the register file
//   id_illegal        one-cycle pulse after an unsupported instr is consumed
module riscv_id #(
  parameter int EX_FUNCT_W  = 4,
  parameter int MEM_FUNCT_W = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   if_id_rdy,
  output logic                   if_id_ack,
  input  logic [31:0]            if_id_instr,
  input  logic [31:0]            if_id_pc,
  output logic                   id_ex_rdy,
  input  logic                   id_ex_ack,
  output logic [EX_FUNCT_W-1:0]  id_ex_funct,
  output logic [31:0]            id_ex_op1,
  output logic [31:0]            id_ex_op2,
  output logic [MEM_FUNCT_W-1:0] id_ex_mem_funct,
  output logic [31:0]            id_ex_mem_data,
  output logic [4:0]             id_ex_wb_rsd,
  input  logic [31:0]            wb_rf_data,
  input  logic [4:0]             wb_rf_rsd,
  input  logic                   wb_rf_write,
  output logic                   id_illegal
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // EX function codes
  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SLL  = 4'd2;
  localparam logic [3:0] F_SLT  = 4'd3;
  localparam logic [3:0] F_SLTU = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_SRL  = 4'd6;
  localparam logic [3:0] F_SRA  = 4'd7;
  localparam logic [3:0] F_OR   = 4'd8;
  localparam logic [3:0] F_AND  = 4'd9;

  // Memory function codes
  localparam logic [3:0] M_NONE = 4'd0;
  localparam logic [3:0] M_LB   = 4'd1;
  localparam logic [3:0] M_LH   = 4'd2;
  localparam logic [3:0] M_LW   = 4'd3;
  localparam logic [3:0] M_LBU  = 4'd4;
  localparam logic [3:0] M_LHU  = 4'd5;
  localparam logic [3:0] M_SB   = 4'd6;
  localparam logic [3:0] M_SH   = 4'd7;
  localparam logic [3:0] M_SW   = 4'd8;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_u;

  assign opc   = if_id_instr[6:0];
  assign rd    = if_id_instr[11:7];
  assign f3    = if_id_instr[14:12];
  assign rs1   = if_id_instr[19:15];
  assign rs2   = if_id_instr[24:20];
  assign f7    = if_id_instr[31:25];
  assign imm_i = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_u = {if_id_instr[31:12], 12'b0};

  // Architectural state
  logic [31:0] rf [0:31];
  logic [31:0] busy;

  // Register read with write-through bypass from WB; x0 always reads 0.
  logic        wb_hit;
  logic [31:0] rs1_val, rs2_val;

  assign wb_hit  = wb_rf_write && (wb_rf_rsd != 5'd0);
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (wb_hit && wb_rf_rsd == rs1) ? wb_rf_data : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (wb_hit && wb_rf_rsd == rs2) ? wb_rf_data : rf[rs2];

  // Decode
  logic        dec_legal, use_rs1, use_rs2, has_rd;
  logic [3:0]  dec_funct, dec_mem, alu_funct;
  logic [31:0] dec_op1, dec_op2, dec_mdata;
  logic [4:0]  dest;

  // Register/immediate ALU ops share funct3 mapping; SUB only exists in OP,
  // never in OP-IMM (ADDI has arbitrary upper immediate bits).
  always_comb begin
    alu_funct = F_ADD;
    case (f3)
      3'b000: alu_funct = (opc == OPC_OP && f7[5]) ? F_SUB : F_ADD;
      3'b001: alu_funct = F_SLL;
      3'b010: alu_funct = F_SLT;
      3'b011: alu_funct = F_SLTU;
      3'b100: alu_funct = F_XOR;
      3'b101: alu_funct = f7[5] ? F_SRA : F_SRL;
      3'b110: alu_funct = F_OR;
      default: alu_funct = F_AND;
    endcase
  end

  always_comb begin
    dec_legal = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    has_rd    = 1'b0;
    dec_funct = F_ADD;
    dec_mem   = M_NONE;
    dec_op1   = 32'd0;
    dec_op2   = 32'd0;
    dec_mdata = 32'd0;
    case (opc)
      OPC_OP: begin
        dec_legal = (f7 == F7_ZERO) ||
                    (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        has_rd    = 1'b1;
        dec_funct = alu_funct;
        dec_op1   = rs1_val;
        dec_op2   = rs2_val;
      end
      OPC_OPIMM: begin
        // Shifts constrain the upper immediate bits; EX uses op2[4:0].
        case (f3)
          3'b001:  dec_legal = (f7 == F7_ZERO);
          3'b101:  dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
        use_rs1   = 1'b1;
        has_rd    = 1'b1;
        dec_funct = alu_funct;
        dec_op1   = rs1_val;
        dec_op2   = imm_i;
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        has_rd    = 1'b1;
        dec_op2   = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        has_rd    = 1'b1;
        dec_op1   = if_id_pc;
        dec_op2   = imm_u;
      end
      OPC_LOAD: begin
        case (f3)
          3'b000:  begin dec_legal = 1'b1; dec_mem = M_LB;  end
          3'b001:  begin dec_legal = 1'b1; dec_mem = M_LH;  end
          3'b010:  begin dec_legal = 1'b1; dec_mem = M_LW;  end
          3'b100:  begin dec_legal = 1'b1; dec_mem = M_LBU; end
          3'b101:  begin dec_legal = 1'b1; dec_mem = M_LHU; end
          default: dec_legal = 1'b0;
        endcase
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        dec_op1 = rs1_val;
        dec_op2 = imm_i;
      end
      OPC_STORE: begin
        case (f3)
          3'b000:  begin dec_legal = 1'b1; dec_mem = M_SB; end
          3'b001:  begin dec_legal = 1'b1; dec_mem = M_SH; end
          3'b010:  begin dec_legal = 1'b1; dec_mem = M_SW; end
          default: dec_legal = 1'b0;
        endcase
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec_op1   = rs1_val;
        dec_op2   = imm_s;
        dec_mdata = rs2_val;
      end
      default: dec_legal = 1'b0;
    endcase
    // Compressed / non-32-bit encodings are never supported.
    if (if_id_instr[1:0] != 2'b11) dec_legal = 1'b0;
  end

  // Stores carry an immediate in the rd field, so they have no destination.
  assign dest = has_rd ? rd : 5'd0;

  // Scoreboard: a busy bit that WB clears this cycle no longer blocks.
  logic [31:0] clr_mask, set_mask, busy_eff;
  logic        hazard, slot_free, accept, accept_legal;

  assign clr_mask  = wb_hit ? (32'd1 << wb_rf_rsd) : 32'd0;
  assign busy_eff  = busy & ~clr_mask;
  assign hazard    = (use_rs1 && busy_eff[rs1]) ||
                     (use_rs2 && busy_eff[rs2]) ||
                     ((dest != 5'd0) && busy_eff[dest]);
  assign slot_free = !id_ex_rdy || id_ex_ack;

  // Illegal instructions are dropped, so they do not wait on hazards.
  assign if_id_ack    = slot_free && (!dec_legal || !hazard);
  assign accept       = if_id_rdy && if_id_ack;
  assign accept_legal = accept && dec_legal;
  assign set_mask     = (accept_legal && dest != 5'd0) ? (32'd1 << dest) : 32'd0;

  // Register file
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wb_hit) begin
      rf[wb_rf_rsd] <= wb_rf_data;
    end
  end

  // Busy bits; set is applied after clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= 32'd0;
    else       busy <= (busy & ~clr_mask) | set_mask;
  end

  // Output slot and illegal pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_ex_rdy       <= 1'b0;
      id_ex_funct     <= '0;
      id_ex_op1       <= 32'd0;
      id_ex_op2       <= 32'd0;
      id_ex_mem_funct <= '0;
      id_ex_mem_data  <= 32'd0;
      id_ex_wb_rsd    <= 5'd0;
      id_illegal      <= 1'b0;
    end else begin
      id_illegal <= accept && !dec_legal;
      if (accept_legal) begin
        id_ex_rdy       <= 1'b1;
        id_ex_funct     <= EX_FUNCT_W'(dec_funct);
        id_ex_op1       <= dec_op1;
        id_ex_op2       <= dec_op2;
        id_ex_mem_funct <= MEM_FUNCT_W'(dec_mem);
        id_ex_mem_data  <= dec_mdata;
        id_ex_wb_rsd    <= dest;
      end else if (id_ex_ack) begin
        id_ex_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_id.sv
module tb_riscv_id;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_id_rdy, if_id_ack;
  logic [31:0] if_id_instr, if_id_pc;
  logic        id_ex_rdy, id_ex_ack;
  logic [3:0]  id_ex_funct, id_ex_mem_funct;
  logic [31:0] id_ex_op1, id_ex_op2, id_ex_mem_data;
  logic [4:0]  id_ex_wb_rsd;
  logic [31:0] wb_rf_data;
  logic [4:0]  wb_rf_rsd;
  logic        wb_rf_write;
  logic        id_illegal;

  riscv_id #(.EX_FUNCT_W(4), .MEM_FUNCT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_id_rdy(if_id_rdy), .if_id_ack(if_id_ack),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .id_ex_rdy(id_ex_rdy), .id_ex_ack(id_ex_ack),
    .id_ex_funct(id_ex_funct), .id_ex_op1(id_ex_op1), .id_ex_op2(id_ex_op2),
    .id_ex_mem_funct(id_ex_mem_funct), .id_ex_mem_data(id_ex_mem_data),
    .id_ex_wb_rsd(id_ex_wb_rsd),
    .wb_rf_data(wb_rf_data), .wb_rf_rsd(wb_rf_rsd), .wb_rf_write(wb_rf_write),
    .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  mf;
    logic [31:0] md;
    logic [4:0]  rsd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ill_seen = 0;
  int   stalls;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction encoders
  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_rr(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] i_lbu(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b100, rd, 7'b0000011};
  endfunction

  function automatic exp_t mk(input logic [3:0] f, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [3:0] mf,
                              input logic [31:0] md, input logic [4:0] rsd);
    exp_t e;
    e.f = f; e.op1 = op1; e.op2 = op2; e.mf = mf; e.md = md; e.rsd = rsd;
    return e;
  endfunction

  // Presents an instruction until accepted (bounded), then drops rdy.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output int st);
    if_id_rdy   = 1'b1;
    if_id_instr = ins;
    if_id_pc    = pc;
    st = 0;
    #1;
    while (!if_id_ack && st < 20) begin
      step();
      st++;
    end
    if (!if_id_ack) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: instr %h never accepted after %0d cycles", ins, st);
    end
    step();
    if_id_rdy = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_rf_write = 1'b1;
    wb_rf_rsd   = r;
    wb_rf_data  = d;
    step();
    wb_rf_write = 1'b0;
  endtask

  // Monitor: pops an expectation for every slot transfer.
  always @(negedge clk) begin
    if (rstn && id_ex_rdy && id_ex_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL slot_unexpected: got transfer rsd %0d op2 %h expected none",
                 id_ex_wb_rsd, id_ex_op2);
      end else begin
        mon_e = exp_q.pop_front();
        chk("slot_funct", {28'd0, id_ex_funct}, {28'd0, mon_e.f});
        chk("slot_op1", id_ex_op1, mon_e.op1);
        chk("slot_op2", id_ex_op2, mon_e.op2);
        chk("slot_mem_funct", {28'd0, id_ex_mem_funct}, {28'd0, mon_e.mf});
        chk("slot_mem_data", id_ex_mem_data, mon_e.md);
        chk("slot_wb_rsd", {27'd0, id_ex_wb_rsd}, {27'd0, mon_e.rsd});
      end
    end
    if (id_illegal) ill_seen++;
  end

  initial begin
    rstn = 1'b0;
    if_id_rdy = 1'b0; if_id_instr = 32'd0; if_id_pc = 32'd0;
    id_ex_ack = 1'b1;
    wb_rf_write = 1'b0; wb_rf_rsd = 5'd0; wb_rf_data = 32'd0;
    #7;
    chk("rst_id_ex_rdy", {31'd0, id_ex_rdy}, 32'd0);
    chk("rst_id_illegal", {31'd0, id_illegal}, 32'd0);
    chk("rst_funct", {28'd0, id_ex_funct}, 32'd0);
    chk("rst_op1", id_ex_op1, 32'd0);
    chk("rst_op2", id_ex_op2, 32'd0);
    chk("rst_mem_funct", {28'd0, id_ex_mem_funct}, 32'd0);
    chk("rst_mem_data", id_ex_mem_data, 32'd0);
    chk("rst_wb_rsd", {27'd0, id_ex_wb_rsd}, 32'd0);
    step();
    rstn = 1'b1;
    step();

    // Back-to-back independent ADDIs
    if_id_rdy = 1'b1;
    if_id_instr = i_addi(5'd1, 5'd0, 12'd5);
    #1 chk("b2b_ack0", {31'd0, if_id_ack}, 32'd1);
    exp_q.push_back(mk(4'd0, 32'd0, 32'd5, 4'd0, 32'd0, 5'd1));
    step();
    if_id_instr = i_addi(5'd2, 5'd0, 12'd7);
    #1 chk("b2b_ack1", {31'd0, if_id_ack}, 32'd1);
    exp_q.push_back(mk(4'd0, 32'd0, 32'd7, 4'd0, 32'd0, 5'd2));
    step();
    if_id_rdy = 1'b0;
    wb_write(5'd2, 32'd7);
    wb_write(5'd1, 32'd5);

    // RAW stall resolved by writeback
    exp_q.push_back(mk(4'd0, 32'd0, 32'd5, 4'd0, 32'd0, 5'd1));
    issue(i_addi(5'd1, 5'd0, 12'd5), 32'd0, stalls);
    if_id_rdy = 1'b1;
    if_id_instr = i_rr(7'd0, 3'b000, 5'd3, 5'd1, 5'd1);
    #1 chk("raw_stall0", {31'd0, if_id_ack}, 32'd0);
    step();
    chk("raw_stall1", {31'd0, if_id_ack}, 32'd0);
    wb_rf_write = 1'b1; wb_rf_rsd = 5'd1; wb_rf_data = 32'd5;
    #1 chk("raw_release", {31'd0, if_id_ack}, 32'd1);
    exp_q.push_back(mk(4'd0, 32'd5, 32'd5, 4'd0, 32'd0, 5'd3));
    step();
    wb_rf_write = 1'b0;
    if_id_rdy = 1'b0;
    wb_write(5'd3, 32'd10);

    // Store / load decode and more ALU patterns
    wb_write(5'd1, 32'h100);
    wb_write(5'd2, 32'hDEADBEEF);
    exp_q.push_back(mk(4'd0, 32'h100, 32'hFFFFFFFC, 4'd8, 32'hDEADBEEF, 5'd0));
    issue(i_sw(5'd2, 5'd1, 12'hFFC), 32'd0, stalls);
    exp_q.push_back(mk(4'd0, 32'h100, 32'd3, 4'd4, 32'd0, 5'd4));
    issue(i_lbu(5'd4, 5'd1, 12'd3), 32'd0, stalls);
    wb_write(5'd4, 32'd0);
    exp_q.push_back(mk(4'd1, 32'hDEADBEEF, 32'h100, 4'd0, 32'd0, 5'd5));
    issue(i_rr(7'b0100000, 3'b000, 5'd5, 5'd2, 5'd1), 32'd0, stalls);
    exp_q.push_back(mk(4'd7, 32'hDEADBEEF, 32'h404, 4'd0, 32'd0, 5'd6));
    issue({7'b0100000, 5'd4, 5'd2, 3'b101, 5'd6, 7'b0010011}, 32'd0, stalls);
    exp_q.push_back(mk(4'd0, 32'd0, 32'hABCDE000, 4'd0, 32'd0, 5'd7));
    issue({20'hABCDE, 5'd7, 7'b0110111}, 32'd0, stalls);
    exp_q.push_back(mk(4'd0, 32'h400, 32'h12345000, 4'd0, 32'd0, 5'd8));
    issue({20'h12345, 5'd8, 7'b0010111}, 32'h400, stalls);
    step();

    // Backpressure
    id_ex_ack = 1'b0;
    exp_q.push_back(mk(4'd0, 32'd0, 32'd1, 4'd0, 32'd0, 5'd9));
    issue(i_addi(5'd9, 5'd0, 12'd1), 32'd0, stalls);
    if_id_rdy = 1'b1;
    if_id_instr = i_addi(5'd10, 5'd0, 12'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_if_id_ack", {31'd0, if_id_ack}, 32'd0);
      chk("bp_rdy_held", {31'd0, id_ex_rdy}, 32'd1);
      chk("bp_op2_stable", id_ex_op2, 32'd1);
      step();
    end
    id_ex_ack = 1'b1;
    #1 chk("bp_release_ack", {31'd0, if_id_ack}, 32'd1);
    exp_q.push_back(mk(4'd0, 32'd0, 32'd2, 4'd0, 32'd0, 5'd10));
    step();
    if_id_rdy = 1'b0;
    step();

    // Illegal instructions
    issue(32'h000000EF, 32'd0, stalls);  // JAL x1
    chk("jal_illegal_pulse", {31'd0, id_illegal}, 32'd1);
    chk("jal_no_slot", {31'd0, id_ex_rdy}, 32'd0);
    step();
    chk("jal_pulse_end", {31'd0, id_illegal}, 32'd0);
    // MUL-encoded OP with busy source x6: consumed despite the hazard
    issue(i_rr(7'b0000001, 3'b000, 5'd12, 5'd6, 5'd6), 32'd0, stalls);
    chk("mul_no_stall", stalls, 32'd0);
    issue(32'h00000010, 32'd0, stalls);  // instr[1:0] != 2'b11
    chk("c16_no_slot", {31'd0, id_ex_rdy}, 32'd0);
    // x12 must not have been marked busy by the illegal MUL
    exp_q.push_back(mk(4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd13));
    issue(i_rr(7'd0, 3'b000, 5'd13, 5'd12, 5'd12), 32'd0, stalls);
    chk("after_illegal_no_stall", stalls, 32'd0);

    // x0 destination and x0 reads
    exp_q.push_back(mk(4'd0, 32'd0, 32'd9, 4'd0, 32'd0, 5'd0));
    issue(i_addi(5'd0, 5'd0, 12'd9), 32'd0, stalls);
    exp_q.push_back(mk(4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd11));
    issue(i_rr(7'd0, 3'b000, 5'd11, 5'd0, 5'd0), 32'd0, stalls);
    chk("x0_no_stall", stalls, 32'd0);
    wb_write(5'd5, 32'h55);

    // Async reset with a pending slot and busy x5
    id_ex_ack = 1'b0;
    exp_q.push_back(mk(4'd0, 32'd0, 32'd3, 4'd0, 32'd0, 5'd5));
    issue(i_addi(5'd5, 5'd0, 12'd3), 32'd0, stalls);
    chk("pre_reset_rdy", {31'd0, id_ex_rdy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_rdy", {31'd0, id_ex_rdy}, 32'd0);
    chk("async_rst_op2", id_ex_op2, 32'd0);
    chk("async_rst_wb_rsd", {27'd0, id_ex_wb_rsd}, 32'd0);
    exp_q.delete();
    step();
    rstn = 1'b1;
    id_ex_ack = 1'b1;
    exp_q.push_back(mk(4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 5'd6));
    issue(i_rr(7'd0, 3'b000, 5'd6, 5'd5, 5'd5), 32'd0, stalls);
    chk("post_reset_no_stall", stalls, 32'd0);
    step();
    step();

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("illegal_pulses", ill_seen, 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
